// File: rtl/linear_predictor_pkg.sv
// ----------------------------------------------------------------------------
// linear_predictor_pkg
//   Shared definitions for the linear predictor.
//   - Default data width, fractional bits and sample-count width. These are
//     the same W/FRAC values the regressor uses, so b0/b1 coming from the
//     coefficient calculator can be applied without any rescaling.
//   - FSM state encoding for the predictor run controller.
// ----------------------------------------------------------------------------
package linear_predictor_pkg;

    // Two's complement fixed point, Q(LP_W-LP_FRAC).LP_FRAC; 1.0 == 2**LP_FRAC.
    localparam int LP_W     = 20;
    localparam int LP_FRAC  = 10;
    localparam int LP_CNT_W = 16;

    // Run controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lp_state_t;

endpackage

// File: rtl/linear_predictor_fx_mul_add_sat.sv
// ----------------------------------------------------------------------------
// linear_predictor_fx_mul_add_sat
//   Combinational back end of the predictor datapath. Takes the full-width
//   product p = b1*x and the intercept b0, and produces
//       y = sat( ((p + 2^(FRAC-1)) >>> FRAC) + b0 )
//   i.e. round-half-up back to FRAC fractional bits, add the intercept, then
//   clamp to the signed W-bit range.
//
// Ports
//   p     in   2W  signed product b1*x (2*FRAC fractional bits)
//   b0    in   W   signed intercept (FRAC fractional bits)
//   y     out  W   rounded, saturated prediction (FRAC fractional bits)
//   clip  out  1   high when y was clamped
// ----------------------------------------------------------------------------
module linear_predictor_fx_mul_add_sat
    import linear_predictor_pkg::*;
#(
    parameter int W    = LP_W,
    parameter int FRAC = LP_FRAC
) (
    input  logic signed [2*W-1:0] p,
    input  logic signed [W-1:0]   b0,
    output logic signed [W-1:0]   y,
    output logic                  clip
);

    // One guard bit above the product so the rounding add can never wrap,
    // even for the most negative * most negative product.
    localparam int PW = 2 * W + 1;

    localparam logic signed [PW-1:0] HALF  = PW'(1) << (FRAC - 1);
    localparam logic signed [PW-1:0] Y_MAX = {{(PW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW-1:0] Y_MIN = {{(PW - W + 1){1'b1}}, {(W - 1){1'b0}}};

    logic signed [PW-1:0] p_ext;
    logic signed [PW-1:0] b0_ext;
    logic signed [PW-1:0] rounded;
    logic signed [PW-1:0] sum;

    always_comb begin
        p_ext   = {p[2*W-1], p};
        b0_ext  = {{(PW - W){b0[W-1]}}, b0};
        // Arithmetic shift after adding one half LSB: ties go towards +inf.
        rounded = (p_ext + HALF) >>> FRAC;
        sum     = rounded + b0_ext;

        clip = 1'b0;
        y    = sum[W-1:0];
        if (sum > Y_MAX) begin
            clip = 1'b1;
            y    = Y_MAX[W-1:0];
        end else if (sum < Y_MIN) begin
            clip = 1'b1;
            y    = Y_MIN[W-1:0];
        end
    end

endmodule

// File: rtl/linear_predictor.sv
// ----------------------------------------------------------------------------
// linear_predictor
//   Applies a fitted line y = b0 + b1*x to a stream of fixed-point samples.
//   A start pulse in IDLE latches b0, b1 and the sample count N; the block
//   then accepts N x values over a valid/ready handshake and returns N
//   predictions, in order, over a second valid/ready handshake.
//
//   Pipeline: stage 1 registers the full-width product b1*x, stage 2
//   rounds, adds b0, saturates and drives y_out. Both stages advance
//   together whenever the output register is empty or being taken, so with
//   no backpressure the block sustains one sample per cycle and y appears
//   two cycles after its x handshake. At most two samples are in flight.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      begin run (honoured only in IDLE)
//   b0         in   W      intercept, signed fixed point
//   b1         in   W      slope, signed fixed point
//   n_samples  in   CNT_W  number of samples in the run
//   x_in       in   W      sample
//   x_valid    in   1      x_in valid
//   x_ready    out  1      x_in accepted this cycle (when x_valid)
//   y_out      out  W      prediction
//   y_valid    out  1      y_out valid
//   y_ready    in   1      consumer takes y_out
//   busy       out  1      high while a run is in progress
//   done       out  1      one-cycle pulse after the last y is taken
//   sat        out  1      sticky: some output in this run was clamped
// ----------------------------------------------------------------------------
module linear_predictor
    import linear_predictor_pkg::*;
#(
    parameter int W     = LP_W,
    parameter int FRAC  = LP_FRAC,
    parameter int CNT_W = LP_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [W-1:0]  b0,
    input  logic signed [W-1:0]  b1,
    input  logic [CNT_W-1:0]     n_samples,
    input  logic signed [W-1:0]  x_in,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic signed [W-1:0]  y_out,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 sat
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lp_state_t              state_reg;
    lp_state_t              state_next;

    logic signed [W-1:0]    b0_reg;
    logic signed [W-1:0]    b1_reg;
    logic [CNT_W-1:0]       n_reg;
    logic [CNT_W-1:0]       in_cnt_reg;
    logic [CNT_W-1:0]       out_cnt_reg;

    logic signed [2*W-1:0]  p_reg;
    logic                   s1_valid_reg;
    logic signed [W-1:0]    y_out_reg;
    logic                   y_valid_reg;
    logic                   sat_reg;

    // ------------------------------------------------------------------
    // Handshake / control terms
    // ------------------------------------------------------------------
    logic                   advance;
    logic                   x_hs;
    logic                   y_hs;
    logic                   last_y;
    logic                   start_acc;

    logic signed [2*W-1:0]  b1_ext;
    logic signed [2*W-1:0]  x_ext;
    logic signed [2*W-1:0]  p_next;
    logic signed [W-1:0]    y_calc;
    logic                   clip;

    // The whole pipe moves only when the output register can be refilled;
    // this single enable is what keeps y_out stable under backpressure.
    assign advance   = !y_valid_reg || y_ready;
    assign x_hs      = x_ready && x_valid;
    assign y_hs      = y_valid_reg && y_ready;
    assign last_y    = (out_cnt_reg + CNT_W'(1)) == n_reg;
    assign start_acc = start && (state_reg == ST_IDLE);

    // Sign-extend both factors to the product width so the multiply is a
    // clean full-precision signed W x W.
    assign b1_ext = {{W{b1_reg[W-1]}}, b1_reg};
    assign x_ext  = {{W{x_in[W-1]}}, x_in};
    assign p_next = b1_ext * x_ext;

    linear_predictor_fx_mul_add_sat #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mul_add_sat (
        .p    (p_reg),
        .b0   (b0_reg),
        .y    (y_calc),
        .clip (clip)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    // An empty run completes immediately.
                    state_next = (n_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (y_hs && last_y) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy    = (state_reg == ST_RUN);
        done    = (state_reg == ST_DONE);
        // in_cnt saturates at N, so once all samples are in x_ready stays low.
        x_ready = (state_reg == ST_RUN) && (in_cnt_reg < n_reg) && advance;
    end

    // ------------------------------------------------------------------
    // Coefficients and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_reg      <= '0;
            b1_reg      <= '0;
            n_reg       <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else if (start_acc) begin
            b0_reg      <= b0;
            b1_reg      <= b1;
            n_reg       <= n_samples;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            if (x_hs) begin
                in_cnt_reg <= in_cnt_reg + CNT_W'(1);
            end
            if (y_hs) begin
                out_cnt_reg <= out_cnt_reg + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-stage datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_reg        <= '0;
            s1_valid_reg <= 1'b0;
            y_out_reg    <= '0;
            y_valid_reg  <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            // Stage 1: an x handshake implies advance, so stage 1 is always
            // free to take a new product here.
            if (x_hs) begin
                p_reg        <= p_next;
                s1_valid_reg <= 1'b1;
            end else if (advance) begin
                s1_valid_reg <= 1'b0;
            end

            // Stage 2: round, add intercept, saturate.
            if (advance) begin
                y_out_reg   <= y_calc;
                y_valid_reg <= s1_valid_reg;
            end

            // The pipe is empty in IDLE, so clearing on start cannot race
            // with a clip from the previous run.
            if (start_acc) begin
                sat_reg <= 1'b0;
            end else if (advance && clip && s1_valid_reg) begin
                sat_reg <= 1'b1;
            end
        end
    end

    assign y_out   = y_out_reg;
    assign y_valid = y_valid_reg;
    assign sat     = sat_reg;

endmodule

// File: tb/tb_linear_predictor.sv
// ----------------------------------------------------------------------------
// tb_linear_predictor
//   Directed bench for linear_predictor. The driver pushes the hand-computed
//   prediction for every accepted x into exp_q; an independent monitor pops
//   and compares on every y handshake.
// ----------------------------------------------------------------------------
module tb_linear_predictor;
    import linear_predictor_pkg::*;

    localparam int W     = LP_W;
    localparam int CNT_W = LP_CNT_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic signed [W-1:0] b0;
    logic signed [W-1:0] b1;
    logic [CNT_W-1:0]    n_samples;
    logic signed [W-1:0] x_in;
    logic                x_valid;
    logic                x_ready;
    logic signed [W-1:0] y_out;
    logic                y_valid;
    logic                y_ready;
    logic                busy;
    logic                done;
    logic                sat;

    linear_predictor dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .b0        (b0),
        .b1        (b1),
        .n_samples (n_samples),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .busy      (busy),
        .done      (done),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int pop_cyc_q[$];
    int done_cnt      = 0;
    int acc_cnt       = 0;
    int last_acc_cyc  = 0;
    int last_pop_cyc  = 0;
    int last_done_cyc = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: compares every y handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_y", int'(y_out), 32'h7fff_ffff);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("y_out", int'(y_out), e);
                    $display("y handshake: y=%0d expected=%0d cycle=%0d", int'(y_out), e, cyc);
                end
                pop_cyc_q.push_back(cyc);
                last_pop_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1 in IDLE.
    task automatic issue_start(input int b0v, input int b1v, input int nv);
        b0        = W'(b0v);
        b1        = W'(b1v);
        n_samples = CNT_W'(nv);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("sat_cleared_on_start", int'(sat), 0);
        chk("busy_after_start", int'(busy), (nv != 0) ? 1 : 0);
        chk("done_after_start", int'(done), (nv == 0) ? 1 : 0);
    endtask

    // Offer one x until accepted; push its expected y on acceptance.
    task automatic send_x(input int xv, input int yv);
        bit ok = 1'b0;
        x_in    = W'(xv);
        x_valid = 1'b1;
        for (int g = 0; g < 100 && !ok; g++) begin
            @(negedge clk);
            if (x_ready) begin
                ok = 1'b1;
                exp_q.push_back(yv);
                acc_cnt++;
                last_acc_cyc = cyc;
                $display("x handshake: x=%0d expected y=%0d cycle=%0d", xv, yv, cyc);
            end
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        if (!ok) chk("x_accept_timeout", 0, 1);
    endtask

    // Wait for the done pulse, then step into IDLE (posedge+1).
    task automatic wait_done(input int d0);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_seen", int'(got), 1);
        @(posedge clk);
        #1;
        chk("done_pulse_count", done_cnt - d0, 1);
        chk("done_is_pulse", int'(done), 0);
    endtask

    task automatic do_run(input int b0v, input int b1v, input int xs[$], input int ys[$],
                          input int exp_sat);
        int d0;
        d0 = done_cnt;
        pop_cyc_q.delete();
        issue_start(b0v, b1v, xs.size());
        foreach (xs[i]) send_x(xs[i], ys[i]);
        chk("x_ready_low_after_last", int'(x_ready), 0);
        wait_done(d0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("outputs_emitted", pop_cyc_q.size(), xs.size());
        chk("sat_flag", int'(sat), exp_sat);
    endtask

    initial begin
        int xs[$];
        int ys[$];
        int d0;

        rst = 1'b1; start = 1'b0; b0 = '0; b1 = '0; n_samples = '0;
        x_in = '0; x_valid = 1'b0; y_ready = 1'b1;
        #1;
        chk("reset_y_valid", int'(y_valid), 0);
        chk("reset_y_out", int'(y_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_sat", int'(sat), 0);
        chk("reset_x_ready", int'(x_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single sample: 2048 + 0.5*4096 = 4096; check latency and done timing.
        xs = {4096}; ys = {4096};
        do_run(2048, 512, xs, ys, 0);
        chk("latency_x_to_y", last_pop_cyc - last_acc_cyc, 2);
        chk("done_after_last_y", last_done_cyc - last_pop_cyc, 1);

        // Negative slope, back-to-back.
        xs = {3072, -1024, 0}; ys = {-3072, 1024, 0};
        do_run(0, -1024, xs, ys, 0);
        chk("back_to_back_span", pop_cyc_q[2] - pop_cyc_q[0], 2);

        // Round half up at the LSB.
        xs = {512, 511, -512, -513}; ys = {1, 0, 0, -1};
        do_run(0, 1, xs, ys, 0);

        // Positive then negative saturation; second start must clear sat.
        xs = {102400}; ys = {524287};
        do_run(0, 524287, xs, ys, 1);
        xs = {102400}; ys = {-524288};
        do_run(0, -524288, xs, ys, 1);

        // Backpressure: y = 2.0*x + 100.
        xs = {10, 20, 30, 40}; ys = {120, 140, 160, 180};
        acc_cnt = 0;
        d0 = done_cnt;
        pop_cyc_q.delete();
        y_ready = 1'b0;
        issue_start(100, 2048, 4);
        fork
            begin
                foreach (xs[i]) send_x(xs[i], ys[i]);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepted_before_stall", acc_cnt, 2);
                chk("bp_y_valid_held", int'(y_valid), 1);
                chk("bp_y_out_held", int'(y_out), 120);
                chk("bp_x_ready_low", int'(x_ready), 0);
                repeat (2) @(negedge clk);
                chk("bp_y_out_stable", int'(y_out), 120);
                chk("bp_still_two", acc_cnt, 2);
                @(posedge clk);
                #1;
                y_ready = 1'b1;
            end
        join
        wait_done(d0);
        chk("bp_scoreboard_empty", exp_q.size(), 0);
        chk("bp_outputs_emitted", pop_cyc_q.size(), 4);

        // Empty run: done on the next cycle, nothing else moves.
        d0 = done_cnt;
        issue_start(0, 1024, 0);
        chk("n0_x_ready", int'(x_ready), 0);
        chk("n0_y_valid", int'(y_valid), 0);
        @(posedge clk);
        #1;
        chk("n0_done_one_cycle", int'(done), 0);
        chk("n0_done_count", done_cnt - d0, 1);

        // Reset mid-run clears outputs immediately.
        issue_start(0, 1024, 4);
        send_x(100, 100);
        send_x(200, 200);
        rst = 1'b1;
        #1;
        chk("midrst_y_valid", int'(y_valid), 0);
        chk("midrst_y_out", int'(y_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_x_ready", int'(x_ready), 0);
        chk("midrst_done", int'(done), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Normal run after reset, with an unsaturated sum (7 + 1.0*... ).
        xs = {7, -9}; ys = {7, -9};
        do_run(0, 1024, xs, ys, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
